// File: rtl/dmac_slave.sv
// Bus-slave front end of the DMA controller. This block holds the CPU-visible registers and
// a FIFO of {SRC,DEST,SIZE} descriptors, starts the master, and serves its pop requests.
module dmac_slave #(
  parameter int FIFO_DEPTH = 8,
  parameter int CNT_W      = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        s_sel,
  input  logic        s_wr,
  input  logic [7:0]  s_addr,
  input  logic [31:0] s_din,
  output logic [31:0] s_dout,
  output logic        m_begin,
  input  logic        m_end,
  input  logic        pop_1,
  input  logic        pop_2,
  input  logic        pop_3,
  output logic [31:0] data1,
  output logic [31:0] data2,
  output logic [31:0] data3,
  output logic        empty,
  output logic        full,
  output logic        rd_ack,
  output logic        rd_err,
  output logic        m_interrupt
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);

  localparam logic [7:0] A_INTR    = 8'h00;
  localparam logic [7:0] A_INT_EN  = 8'h01;
  localparam logic [7:0] A_SRC     = 8'h02;
  localparam logic [7:0] A_DEST    = 8'h03;
  localparam logic [7:0] A_SIZE    = 8'h04;
  localparam logic [7:0] A_PUSH    = 8'h05;
  localparam logic [7:0] A_START   = 8'h06;
  localparam logic [7:0] A_INT_CLR = 8'h07;
  localparam logic [7:0] A_STATUS  = 8'h08;
  localparam logic [7:0] A_COUNT   = 8'h09;

  typedef enum logic [1:0] {S_IDLE, S_START, S_BUSY, S_DONE} state_t;

  state_t             r_state;
  logic               r_m_begin;
  logic               r_int_en;
  logic               r_opdone;
  logic               r_wr_err;
  logic [31:0]        r_src;
  logic [31:0]        r_dest;
  logic [31:0]        r_size;
  logic [31:0]        r_data1;
  logic [31:0]        r_data2;
  logic [31:0]        r_data3;
  logic               r_rd_ack;
  logic               r_rd_err;
  logic [PTR_W-1:0]   r_wptr;
  logic [PTR_W-1:0]   r_rptr;
  logic [CNT_W-1:0]   r_count;
  logic [95:0]        r_mem [FIFO_DEPTH];

  logic w_wr;
  logic w_rd;
  logic w_push_req;
  logic w_start_req;
  logic w_clr_op;
  logic w_clr_err;
  logic w_pop_req;
  logic w_empty;
  logic w_full;
  logic w_push_ok;
  logic w_pop_ok;
  logic w_busy;

  assign w_wr        = s_sel & s_wr;
  assign w_rd        = s_sel & ~s_wr;
  assign w_push_req  = w_wr && (s_addr == A_PUSH)    && s_din[0];
  assign w_start_req = w_wr && (s_addr == A_START)   && s_din[0];
  assign w_clr_op    = w_wr && (s_addr == A_INT_CLR) && s_din[0];
  assign w_clr_err   = w_wr && (s_addr == A_INT_CLR) && s_din[1];
  assign w_pop_req   = pop_1 | pop_2 | pop_3;
  assign w_empty     = (r_count == '0);
  assign w_full      = (r_count == CNT_W'(FIFO_DEPTH));
  // Full/empty are judged on the pre-edge count, so a simultaneous pop never frees room for a push.
  assign w_push_ok   = w_push_req & ~w_full;
  assign w_pop_ok    = w_pop_req & ~w_empty;
  assign w_busy      = (r_state != S_IDLE);

  // NOTE: the descriptor storage has no reset; count and pointers alone define which entries are valid.
  always_ff @(posedge clk) begin
    if (w_push_ok) r_mem[r_wptr] <= {r_src, r_dest, r_size};
  end

  // NOTE: every sequential block uses non-blocking assignments so all state updates see pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_int_en <= 1'b0;
      r_src    <= '0;
      r_dest   <= '0;
      r_size   <= '0;
      r_wr_err <= 1'b0;
      r_wptr   <= '0;
      r_rptr   <= '0;
      r_count  <= '0;
      r_data1  <= '0;
      r_data2  <= '0;
      r_data3  <= '0;
      r_rd_ack <= 1'b0;
      r_rd_err <= 1'b0;
    end else begin
      if (w_wr) begin
        unique case (s_addr)
          A_INT_EN: r_int_en <= s_din[0];
          A_SRC:    r_src    <= s_din;
          A_DEST:   r_dest   <= s_din;
          A_SIZE:   r_size   <= s_din;
          default:  ;
        endcase
      end

      if (w_push_req && w_full) r_wr_err <= 1'b1;
      else if (w_clr_err)       r_wr_err <= 1'b0;

      if (w_push_ok) r_wptr <= r_wptr + PTR_W'(1);
      if (w_pop_ok) begin
        r_rptr <= r_rptr + PTR_W'(1);
        {r_data1, r_data2, r_data3} <= r_mem[r_rptr];
      end

      unique case ({w_push_ok, w_pop_ok})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase

      r_rd_ack <= w_pop_ok;
      r_rd_err <= w_pop_req & w_empty;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_m_begin <= 1'b0;
      r_opdone  <= 1'b0;
    end else begin
      r_m_begin <= 1'b0;
      unique case (r_state)
        S_IDLE:  if (w_start_req && !w_empty) r_state <= S_START;
        S_START: begin
          r_m_begin <= 1'b1;
          r_state   <= S_BUSY;
        end
        S_BUSY:  if (m_end) r_state <= S_DONE;
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase

      if (r_state == S_DONE) r_opdone <= 1'b1;
      else if (w_clr_op)     r_opdone <= 1'b0;
    end
  end

  always_comb begin
    s_dout = '0;
    if (w_rd) begin
      unique case (s_addr)
        A_INTR:   s_dout = {31'b0, r_opdone};
        A_INT_EN: s_dout = {31'b0, r_int_en};
        A_SRC:    s_dout = r_src;
        A_DEST:   s_dout = r_dest;
        A_SIZE:   s_dout = r_size;
        A_STATUS: s_dout = {28'b0, w_full, w_empty, w_busy, r_wr_err};
        A_COUNT:  s_dout = {{(32-CNT_W){1'b0}}, r_count};
        default:  s_dout = '0;
      endcase
    end
  end

  assign m_begin     = r_m_begin;
  assign data1       = r_data1;
  assign data2       = r_data2;
  assign data3       = r_data3;
  assign empty       = w_empty;
  assign full        = w_full;
  assign rd_ack      = r_rd_ack;
  assign rd_err      = r_rd_err;
  assign m_interrupt = r_opdone & r_int_en;

endmodule

// File: tb/tb_dmac_slave.sv
// Self-checking bench for dmac_slave: register vector table, directed start/pop/interrupt
// sequences, and a randomized push/pop run against a queue-based descriptor model.
module tb_dmac_slave;

  logic        clk;
  logic        reset;
  logic        s_sel;
  logic        s_wr;
  logic [7:0]  s_addr;
  logic [31:0] s_din;
  logic [31:0] s_dout;
  logic        m_begin;
  logic        m_end;
  logic        pop_1, pop_2, pop_3;
  logic [31:0] data1, data2, data3;
  logic        empty, full, rd_ack, rd_err, m_interrupt;

  int n_checks = 0;
  int n_fail   = 0;

  dmac_slave #(.FIFO_DEPTH(8), .CNT_W(4)) dut (
    .clk(clk), .reset(reset), .s_sel(s_sel), .s_wr(s_wr), .s_addr(s_addr),
    .s_din(s_din), .s_dout(s_dout), .m_begin(m_begin), .m_end(m_end),
    .pop_1(pop_1), .pop_2(pop_2), .pop_3(pop_3), .data1(data1), .data2(data2),
    .data3(data3), .empty(empty), .full(full), .rd_ack(rd_ack), .rd_err(rd_err),
    .m_interrupt(m_interrupt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_wr(input logic [7:0] a, input logic [31:0] d);
    s_sel = 1'b1; s_wr = 1'b1; s_addr = a; s_din = d;
    tick();
    s_sel = 1'b0; s_wr = 1'b0;
  endtask

  task automatic bus_rd(input logic [7:0] a, output logic [31:0] d);
    s_sel = 1'b1; s_wr = 1'b0; s_addr = a;
    #1;
    d = s_dout;
    s_sel = 1'b0;
  endtask

  task automatic push_desc(input logic [31:0] src, input logic [31:0] dst, input logic [31:0] sz);
    bus_wr(8'h02, src);
    bus_wr(8'h03, dst);
    bus_wr(8'h04, sz);
    bus_wr(8'h05, 32'h1);
  endtask

  typedef struct {
    logic        wr;
    logic [7:0]  addr;
    logic [31:0] din;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[15];
  logic [31:0] rd;
  logic [95:0] q[$];
  logic [95:0] ent;

  initial begin
    reset = 1'b1; s_sel = 0; s_wr = 0; s_addr = 0; s_din = 0;
    m_end = 0; pop_1 = 0; pop_2 = 0; pop_3 = 0;
    tick(); tick();
    reset = 1'b0;
    tick();

    // reset state
    check("rst_empty", {31'b0, empty}, 1);
    check("rst_full", {31'b0, full}, 0);
    check("rst_m_begin", {31'b0, m_begin}, 0);
    check("rst_rd_ack", {31'b0, rd_ack}, 0);
    check("rst_rd_err", {31'b0, rd_err}, 0);
    check("rst_irq", {31'b0, m_interrupt}, 0);
    check("rst_data1", data1, 0);

    // register map table
    vecs[0]  = '{1'b0, 8'h00, 32'h0, 32'h0};
    vecs[1]  = '{1'b0, 8'h08, 32'h0, 32'h4};
    vecs[2]  = '{1'b0, 8'h09, 32'h0, 32'h0};
    vecs[3]  = '{1'b1, 8'h02, 32'hdeadbeef, 32'hdeadbeef};
    vecs[4]  = '{1'b1, 8'h03, 32'h12345678, 32'h12345678};
    vecs[5]  = '{1'b1, 8'h04, 32'h000000ff, 32'h000000ff};
    vecs[6]  = '{1'b1, 8'h01, 32'hffffffff, 32'h1};
    vecs[7]  = '{1'b1, 8'h01, 32'h0, 32'h0};
    vecs[8]  = '{1'b1, 8'h0a, 32'hffffffff, 32'h0};
    vecs[9]  = '{1'b1, 8'h00, 32'hffffffff, 32'h0};
    vecs[10] = '{1'b0, 8'h05, 32'h0, 32'h0};
    vecs[11] = '{1'b0, 8'h07, 32'h0, 32'h0};
    vecs[12] = '{1'b0, 8'hff, 32'h0, 32'h0};
    vecs[13] = '{1'b1, 8'h06, 32'h1, 32'h0};
    vecs[14] = '{1'b0, 8'h08, 32'h0, 32'h4};
    for (int i = 0; i < 15; i++) begin
      if (vecs[i].wr) bus_wr(vecs[i].addr, vecs[i].din);
      bus_rd(vecs[i].addr, rd);
      check($sformatf("reg_vec%0d_a%0h", i, vecs[i].addr), rd, vecs[i].exp);
    end
    check("start_empty_no_begin", {31'b0, m_begin}, 0);

    // single descriptor, start, pop
    push_desc(32'h10, 32'h20, 32'h1);
    bus_wr(8'h06, 32'h1);
    check("begin_cyc1", {31'b0, m_begin}, 0);
    tick();
    check("begin_cyc2", {31'b0, m_begin}, 1);
    tick();
    check("begin_cyc3", {31'b0, m_begin}, 0);
    pop_1 = 1; pop_2 = 1; pop_3 = 1;
    tick();
    pop_1 = 0; pop_2 = 0; pop_3 = 0;
    check("pop_ack", {31'b0, rd_ack}, 1);
    check("pop_d1", data1, 32'h10);
    check("pop_d2", data2, 32'h20);
    check("pop_d3", data3, 32'h1);
    check("pop_empty", {31'b0, empty}, 1);
    tick();
    check("pop_ack_drop", {31'b0, rd_ack}, 0);

    // START while BUSY is ignored
    push_desc(32'h30, 32'h40, 32'h2);
    bus_wr(8'h06, 32'h1);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("busy_start_nobegin%0d", i), {31'b0, m_begin}, 0);
      tick();
    end
    bus_rd(8'h08, rd);
    check("busy_status", rd, 32'h2);

    // m_end, opdone with coincident clear, interrupt
    bus_wr(8'h01, 32'h1);
    m_end = 1'b1;
    tick();
    m_end = 1'b0;
    check("irq_in_done", {31'b0, m_interrupt}, 0);
    bus_wr(8'h07, 32'h1);
    check("irq_set_wins", {31'b0, m_interrupt}, 1);
    bus_rd(8'h00, rd);
    check("intr_reg", rd, 32'h1);
    bus_rd(8'h08, rd);
    check("idle_after_done", rd, 32'h0);
    bus_wr(8'h07, 32'h1);
    check("irq_cleared", {31'b0, m_interrupt}, 0);
    m_end = 1'b1;
    tick();
    m_end = 1'b0;
    bus_rd(8'h08, rd);
    check("m_end_idle_ignored", rd, 32'h0);

    // drain, then START with empty FIFO
    pop_2 = 1; tick(); pop_2 = 0;
    check("drain_ack", {31'b0, rd_ack}, 1);
    check("drain_d1", data1, 32'h30);
    bus_wr(8'h06, 32'h1);
    tick();
    check("empty_start_nobegin", {31'b0, m_begin}, 0);
    bus_rd(8'h08, rd);
    check("empty_start_status", rd, 32'h4);

    // overflow and order across the pointer wrap
    for (int i = 0; i < 9; i++) begin
      push_desc(32'h1000 + i, 32'h2000 + i, i + 1);
      if (i == 7) check("full_after8", {31'b0, full}, 1);
      if (i == 6) check("notfull_after7", {31'b0, full}, 0);
    end
    bus_rd(8'h08, rd);
    check("ovf_status", rd, 32'h9);
    bus_rd(8'h09, rd);
    check("ovf_count", rd, 32'h8);
    pop_2 = 1;
    for (int i = 0; i < 8; i++) begin
      tick();
      check($sformatf("wrap_ack%0d", i), {31'b0, rd_ack}, 1);
      check($sformatf("wrap_d1_%0d", i), data1, 32'h1000 + i);
      check($sformatf("wrap_d3_%0d", i), data3, i + 1);
    end
    pop_2 = 0;
    check("wrap_empty", {31'b0, empty}, 1);

    // pop when empty
    pop_3 = 1; tick(); pop_3 = 0;
    check("uf_rd_err", {31'b0, rd_err}, 1);
    check("uf_rd_ack", {31'b0, rd_ack}, 0);
    check("uf_d1_hold", data1, 32'h1007);
    check("uf_d2_hold", data2, 32'h2007);
    check("uf_d3_hold", data3, 32'h8);
    tick();
    check("uf_rd_err_drop", {31'b0, rd_err}, 0);
    bus_wr(8'h07, 32'h2);
    bus_rd(8'h08, rd);
    check("wr_err_clear", rd, 32'h4);

    // reset mid-BUSY with three descriptors queued
    for (int i = 0; i < 3; i++) push_desc(32'h50 + i, 32'h60, 32'h3);
    bus_wr(8'h06, 32'h1);
    tick();
    check("pre_rst_begin", {31'b0, m_begin}, 1);
    reset = 1'b1;
    #1;
    check("arst_m_begin", {31'b0, m_begin}, 0);
    check("arst_empty", {31'b0, empty}, 1);
    tick();
    check("rst_mid_empty", {31'b0, empty}, 1);
    check("rst_mid_irq", {31'b0, m_interrupt}, 0);
    bus_rd(8'h09, rd);
    check("rst_mid_count", rd, 32'h0);
    reset = 1'b0;
    tick();

    // randomized push/pop against a queue model
    begin
      logic [31:0] m_src, m_dst, m_sz, m_d1, m_d2, m_d3;
      logic m_wr_err, exp_ack, exp_err, do_pop, was_full, was_empty;
      int op, pop_pct;
      m_src = 0; m_dst = 0; m_sz = 0; m_d1 = 0; m_d2 = 0; m_d3 = 0; m_wr_err = 0;
      q.delete();
      for (int it = 0; it < 400; it++) begin
        pop_pct = ((it / 50) % 2 == 0) ? 20 : 65;
        op = $urandom_range(0, 9);
        do_pop = ($urandom_range(0, 99) < pop_pct);
        s_sel = 1'b0; s_wr = 1'b1; s_din = $urandom;
        was_full = (q.size() == 8);
        was_empty = (q.size() == 0);
        exp_ack = do_pop && !was_empty;
        exp_err = do_pop && was_empty;
        if (exp_ack) begin
          ent = q.pop_front();
          {m_d1, m_d2, m_d3} = ent;
        end
        if (op <= 2) begin
          s_sel = 1'b1; s_addr = 8'(op + 2);
          if (op == 0) m_src = s_din;
          else if (op == 1) m_dst = s_din;
          else m_sz = s_din;
        end else if (op <= 6) begin
          s_sel = 1'b1; s_addr = 8'h05;
          s_din[0] = (op != 6);
          if (op != 6) begin
            if (was_full) m_wr_err = 1'b1;
            else q.push_back({m_src, m_dst, m_sz});
          end
        end else if (op == 7) begin
          s_sel = 1'b1; s_addr = 8'h07; s_din = 32'h2;
          m_wr_err = 1'b0;
        end
        {pop_1, pop_2, pop_3} = do_pop ? 3'(1 << $urandom_range(0, 2)) : 3'b000;
        tick();
        s_sel = 1'b0; s_wr = 1'b0;
        pop_1 = 0; pop_2 = 0; pop_3 = 0;
        check($sformatf("rnd%0d_ack", it), {31'b0, rd_ack}, {31'b0, exp_ack});
        check($sformatf("rnd%0d_err", it), {31'b0, rd_err}, {31'b0, exp_err});
        check($sformatf("rnd%0d_d1", it), data1, m_d1);
        check($sformatf("rnd%0d_d2", it), data2, m_d2);
        check($sformatf("rnd%0d_d3", it), data3, m_d3);
        bus_rd(8'h09, rd);
        check($sformatf("rnd%0d_count", it), rd, q.size());
        bus_rd(8'h08, rd);
        check($sformatf("rnd%0d_status", it), rd,
              {28'b0, q.size() == 8, q.size() == 0, 1'b0, m_wr_err});
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
